// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor.
// Instruction field widths/positions and the fetch FSM state encoding.
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;
    localparam int REG_W    = 3;
    localparam int FUNC_W   = 3;
    localparam int IMM_W    = 6;
    localparam int OFFSET_W = 9;

    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RS_LSB   = 6;
    localparam int RT_LSB   = 3;
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = 0;
    localparam int OFF_LSB  = 3;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Valid/instr/pc pipeline register with load, hold and flush controls.
// Ports: clk, rst_n, i_load, i_flush, i_instr, i_pc -> o_valid, o_instr, o_pc.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    // Flush only drops valid; stale payload is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over req/ack, holds IF/ID plus a skid slot.
// Ports: imem req/addr/ack/rdata, stall, redirect, IF/ID outputs and fields.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int             PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [PC_W-1:0]     if_id_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [FUNC_W-1:0]   func,
    output logic [IMM_W-1:0]    imm,
    output logic [OFFSET_W-1:0] offset
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_req_addr;
    logic            r_req;
    logic            r_discard;

    fetch_state_e    w_state_d;
    logic [PC_W-1:0] w_pc_d;
    logic [PC_W-1:0] w_addr_d;
    logic            w_req_d;
    logic            w_discard_d;

    logic               w_ack;
    logic               w_ifid_load;
    logic               w_ifid_flush;
    logic [INSTR_W-1:0] w_ifid_instr;
    logic [PC_W-1:0]    w_ifid_pc;
    logic               w_skid_load;
    logic               w_skid_flush;
    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;

    // An ack only counts while our request is outstanding.
    assign w_ack = imem_ack & r_req;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_addr_d     = r_req_addr;
        w_req_d      = r_req;
        w_discard_d  = r_discard;
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_instr = imem_rdata;
        w_ifid_pc    = r_req_addr;
        w_skid_load  = 1'b0;
        w_skid_flush = 1'b0;

        if (redirect_valid) begin
            w_pc_d       = redirect_pc;
            w_state_d    = S_REQ;
            w_ifid_flush = 1'b1;
            w_skid_flush = 1'b1;
            if (r_req && !imem_ack) begin
                // Keep the address stable; drop its response later.
                w_discard_d = 1'b1;
            end else begin
                w_req_d     = 1'b1;
                w_addr_d    = redirect_pc;
                w_discard_d = 1'b0;
            end
        end else begin
            unique case (r_state)
                S_REQ: begin
                    // Decode consumed IF/ID and nothing new arrived.
                    w_ifid_flush = !stall;
                    if (!r_req) begin
                        w_req_d  = 1'b1;
                        w_addr_d = r_pc;
                    end else if (w_ack) begin
                        if (r_discard) begin
                            w_discard_d = 1'b0;
                            w_addr_d    = r_pc;
                        end else if (!stall || !if_id_valid) begin
                            w_ifid_flush = 1'b0;
                            w_ifid_load  = 1'b1;
                            w_pc_d       = r_req_addr + PC_ONE;
                            w_addr_d     = r_req_addr + PC_ONE;
                        end else begin
                            w_skid_load = 1'b1;
                            w_req_d     = 1'b0;
                            w_state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_ifid_load  = w_skid_valid;
                        w_ifid_instr = w_skid_instr;
                        w_ifid_pc    = w_skid_pc;
                        w_skid_flush = 1'b1;
                        w_pc_d       = w_skid_pc + PC_ONE;
                        w_addr_d     = w_skid_pc + PC_ONE;
                        w_req_d      = 1'b1;
                        w_state_d    = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_req      <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_req_addr <= w_addr_d;
            r_req      <= w_req_d;
            r_discard  <= w_discard_d;
        end
    end

    if_id_reg #(.PC_W(PC_W)) u_if_id (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_instr (w_ifid_instr),
        .i_pc    (w_ifid_pc),
        .o_valid (if_id_valid),
        .o_instr (if_id_instr),
        .o_pc    (if_id_pc)
    );

    if_id_reg #(.PC_W(PC_W)) u_skid (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_load  (w_skid_load),
        .i_flush (w_skid_flush),
        .i_instr (imem_rdata),
        .i_pc    (r_req_addr),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_req_addr;

    assign opcode = if_id_instr[OPC_LSB  +: OPCODE_W];
    assign rd     = if_id_instr[RD_LSB   +: REG_W];
    assign rs     = if_id_instr[RS_LSB   +: REG_W];
    assign rt     = if_id_instr[RT_LSB   +: REG_W];
    assign func   = if_id_instr[FUNC_LSB +: FUNC_W];
    assign imm    = if_id_instr[IMM_LSB  +: IMM_W];
    assign offset = if_id_instr[OFF_LSB  +: OFFSET_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
// Memory returns rdata = addr + 16'h1000; acks are automatic or hand-driven.
module tb_fetch_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  func;
    logic [5:0]  imm;
    logic [8:0]  offset;

    logic auto_ack;
    logic man_ack;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .opcode         (opcode),
        .rd             (rd),
        .rs             (rs),
        .rt             (rt),
        .func           (func),
        .imm            (imm),
        .offset         (offset)
    );

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = imem_addr + 16'h1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a);
        exp_t e;
        e.instr = a + 16'h1000;
        e.pc    = a;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
            chk({tag, "_instr"}, 32'(if_id_instr), 32'(e.instr));
            chk({tag, "_pc"}, 32'(if_id_pc), 32'(e.pc));
        end
    endtask

    task automatic chk_fields(input string tag, input logic [15:0] w);
        logic [15:0] v;
        v = w;
        chk({tag, "_opc"}, 32'(opcode), 32'(v[15:12]));
        chk({tag, "_rd"}, 32'(rd), 32'(v[11:9]));
        chk({tag, "_rs"}, 32'(rs), 32'(v[8:6]));
        chk({tag, "_rt"}, 32'(rt), 32'(v[5:3]));
        chk({tag, "_func"}, 32'(func), 32'(v[2:0]));
        chk({tag, "_imm"}, 32'(imm), 32'(v[5:0]));
        chk({tag, "_off"}, 32'(offset), 32'(v[11:3]));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        auto_ack = 1'b0;
        man_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_instr", 32'(if_id_instr), 32'd0);
        chk("rst_pc", 32'(if_id_pc), 32'd0);
        chk_fields("rst", 16'h0000);

        // Zero-wait memory: one instruction per cycle.
        auto_ack = 1'b1;
        reset_n = 1'b1;
        step();
        for (int a = 0; a < 3; a++) begin
            chk("zw_req", 32'(imem_req), 32'd1);
            chk("zw_addr", 32'(imem_addr), 32'(a));
            push(16'(a));
            step();
            pop_check("zw");
        end

        // Stall while the ack for 3 arrives: goes to the skid.
        stall = 1'b1;
        chk("st_addr", 32'(imem_addr), 32'd3);
        push(16'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_req", 32'(imem_req), 32'd0);
            chk("st_valid", 32'(if_id_valid), 32'd1);
            chk("st_instr", 32'(if_id_instr), 32'h1002);
            chk("st_pc", 32'(if_id_pc), 32'd2);
        end
        stall = 1'b0;
        step();
        pop_check("st_rel");
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", 32'(imem_addr), 32'd4);
        push(16'd4);
        step();
        auto_ack = 1'b0;
        pop_check("rel_next");

        // Redirect while a slow request to 5 is outstanding.
        chk("slow_req", 32'(imem_req), 32'd1);
        chk("slow_addr", 32'(imem_addr), 32'd5);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", 32'(if_id_valid), 32'd0);
        chk("rd_addr_hold", 32'(imem_addr), 32'd5);
        chk("rd_req", 32'(imem_req), 32'd1);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        chk("drop_valid", 32'(if_id_valid), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", 32'(imem_addr), 32'h0040);
        man_ack = 1'b1;
        push(16'h0040);
        step();
        man_ack = 1'b0;
        pop_check("rd_load");
        chk_fields("f40", 16'h1040);

        // Redirect, ack and stall together.
        stall = 1'b1;
        man_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        man_ack = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        chk("ra_valid", 32'(if_id_valid), 32'd0);
        chk("ra_req", 32'(imem_req), 32'd1);
        chk("ra_addr", 32'(imem_addr), 32'hFFFF);

        // PC wrap.
        man_ack = 1'b1;
        push(16'hFFFF);
        step();
        man_ack = 1'b0;
        pop_check("wrap");
        chk("wrap_addr", 32'(imem_addr), 32'h0000);
        chk_fields("fff", 16'h0FFF);

        // Asynchronous reset mid-request, then a stale ack.
        #3;
        reset_n = 1'b0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_valid", 32'(if_id_valid), 32'd0);
        chk("mr_instr", 32'(if_id_instr), 32'd0);
        chk("mr_pc", 32'(if_id_pc), 32'd0);
        chk("mr_func", 32'(func), 32'd0);
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        chk("stale_valid", 32'(if_id_valid), 32'd0);
        chk("post_req", 32'(imem_req), 32'd1);
        chk("post_addr", 32'(imem_addr), 32'h0000);
        push(16'h0000);
        step();
        man_ack = 1'b0;
        pop_check("post_rst");

        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 16-bit pipelined processor: owns the PC, fetches 16-bit instruction words over a req/ack instruction-memory port, and holds the IF/ID pipeline register.
- Supplies the raw instruction and pre-sliced fields (opcode, rd, rs, rt, func, imm, offset) directly to the decode stage.
- Handles back-pressure (stall) and control-flow redirect (flush) coming from later stages.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_W, 16, PC / instruction-address width. Word addressed, so the next PC is PC+1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held high until acked
- imem_addr  out  PC_W  fetch address, stable while imem_req is high
- imem_ack  in  1  instruction data valid this cycle
- imem_rdata  in  16  instruction word
- stall  in  1  decode cannot accept a new instruction; hold IF/ID
- redirect_valid  in  1  branch/jump taken; flush and restart
- redirect_pc  in  PC_W  new fetch target
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  16  IF/ID instruction
- if_id_pc  out  PC_W  address of the IF/ID instruction
- opcode  out  4  if_id_instr[15:12]
- rd  out  3  if_id_instr[11:9]
- rs  out  3  if_id_instr[8:6]
- rt  out  3  if_id_instr[5:3]
- func  out  3  if_id_instr[2:0]
- imm  out  6  if_id_instr[5:0]
- offset  out  9  if_id_instr[11:3]

Behaviour:
- Reset (async, reset_n=0):
  - pc_q = RESET_PC; state = S_REQ.
  - imem_req = 0 while reset is asserted.
  - if_id_valid = 0; if_id_instr = 0; if_id_pc = 0.
  - skid buffer empty; discard flag = 0.
- First request: imem_req rises in the first cycle after reset_n deasserts, with imem_addr = RESET_PC.
- Field outputs: purely combinational slices of if_id_instr, so they are 0 after reset.
- Request address: imem_addr comes from a request-address register, latched from pc_q when a request starts. A redirect never changes it mid-request.
- Ack timing: ack may arrive in the same cycle as req or any later cycle. Latency from ack to if_id_valid is one clock.
- FSM states:
  - S_REQ: imem_req=1. On ack with discard=1, drop the data, clear discard, start a new request at pc_q, stay in S_REQ. On ack with no stall, or with if_id_valid=0, load IF/ID (valid=1, instr=rdata, pc=request address), set pc_q = request address + 1, issue the next request, stay in S_REQ. On ack with stall and if_id_valid=1, write rdata into the skid buffer and go to S_HOLD.
  - S_HOLD: imem_req=0. When stall=0, move skid into IF/ID, set pc_q = skid pc + 1, go to S_REQ.
- Stall with no ack: IF/ID holds its values and the PC does not advance. An outstanding request stays pending.
- Redirect (highest priority, overrides stall and ack):
  - Next cycle: pc_q = redirect_pc, if_id_valid = 0, skid cleared, state = S_REQ.
  - An ack in the same cycle as the redirect is dropped.
  - If a request is outstanding and unacked, set discard so that request's eventual response is dropped.
  - A new request at redirect_pc is issued once no request is outstanding.
- PC wraps modulo 2^PC_W: 16'hFFFF + 1 = 16'h0000. No error is flagged.
- Reset mid-request: all state clears immediately. A late ack after reset is ignored because no request is outstanding.
- There is never more than one outstanding request.

Decomposition:
- Shared package cpu_pkg:
  - OPCODE_W=4, REG_W=3, FUNC_W=3, IMM_W=6, OFFSET_W=9, INSTR_W=16.
  - Field bit-position localparams.
  - Fetch-state enum (S_REQ, S_HOLD).
  - The same field constants are reused by decode.
- One sub-module: if_id_reg. It is the valid/instr/pc pipeline register with load, hold and flush controls, reused for the skid buffer.

Test Plan:
- Reset release, zero-wait memory (ack tied to req, rdata = addr+16'h1000) -> addresses 0,1,2,…. if_id_instr = 16'h1000,16'h1001,…, one per cycle. if_id_valid rises 1 cycle after the first ack.
- stall held high for 3 cycles while an ack arrives -> IF/ID holds 16'h1002 and the skid captures 16'h1003. imem_req stays 0. After the release, if_id_instr = 16'h1003 and the next address is 4.
- redirect_valid with redirect_pc=16'h0040 while a 3-cycle-latency request to 5 is outstanding -> the response for 5 is dropped. Next request address = 16'h0040. if_id_valid stays 0 until the 16'h0040 data loads.
- redirect and ack in the same cycle, with stall=1 -> data dropped, IF/ID flushed (valid=0), pc_q = redirect_pc.
- pc_q = 16'hFFFF fetch acked -> if_id_pc = 16'hFFFF and the next request address = 16'h0000.
- reset_n pulsed low mid-request -> all outputs return to 0 asynchronously. The first new request is at RESET_PC, and the stale ack is ignored.
